mem_req_arbiter: RTL and testbench
==================================

// Module: mem_req_arbiter
// PURPOSE
//  Shares the single line-refill memory port (mem_req/mem_addr/mem_data_in/mem_ready)
//  between NUM_REQ requesters (I-cache miss handler, prefetcher, ...) with round-robin
//  grant. Exactly one transaction is outstanding. A refill-timeout watchdog returns an
//  error response when memory never answers. Sits between the cache refill logic and
//  mem_sim (or the real memory model).
// PARAMETERS
//  NUM_REQ        2    number of requesters (>=2)
//  ADDR_W         32   address width
//  LINE_W         128  refill line width
//  TIMEOUT_CYCLES 64   max BUSY cycles without mem_ready; 0 = watchdog disabled
// PORTS
//  clk          in   1               clock, all state updates on rising edge
//  rst          in   1               reset, asynchronous, active-high
//  req_valid    in   NUM_REQ         per-requester request, level, held until req_ack
//  req_addr     in   NUM_REQ*ADDR_W  flattened addresses, slice i = [i*ADDR_W +: ADDR_W]
//  req_ack      out  NUM_REQ         one-hot, 1-cycle pulse: request accepted, addr sampled
//  resp_valid   out  NUM_REQ         one-hot, 1-cycle pulse: response for granted requester
//  resp_err     out  1               qualifies resp_valid: 1 = timeout, resp_data = 0
//  resp_data    out  LINE_W          refill line, valid while any resp_valid bit is high
//  busy         out  1               high in BUSY and RESP states
//  mem_req      out  1               memory request, level, held until mem_ready
//  mem_addr     out  ADDR_W          memory address, stable while mem_req=1, 0 otherwise
//  mem_data_in  in   LINE_W          memory line data, sampled when mem_ready=1
//  mem_ready    in   1               memory done, data valid this cycle
// BEHAVIOUR
//  Reset (async, immediate): state=IDLE, rr_ptr=0, timeout counter=0, all outputs 0.
//  Reset mid-transaction abandons it: no resp_valid, mem_req drops with rst.
//  All outputs are registered. FSM states: IDLE, BUSY, RESP.
//  IDLE:
//   - If req_valid!=0, grant g = first set index searching rr_ptr, rr_ptr+1, ... mod NUM_REQ.
//   - Same edge: latch req_addr[g]; next cycle req_ack[g]=1 (one cycle only), mem_req=1,
//     mem_addr=latched addr, state BUSY. Latency req_valid -> mem_req: 1 cycle.
//   - mem_ready ignored.
//  BUSY:
//   - mem_req=1, mem_addr constant. Counter increments each cycle.
//   - On edge with mem_ready=1: capture mem_data_in into resp_data. Next cycle:
//     resp_valid[g]=1, resp_err=0, mem_req=0, mem_addr=0, state RESP.
//   - If TIMEOUT_CYCLES!=0 and counter reaches TIMEOUT_CYCLES without mem_ready: same
//     transition with resp_err=1 and resp_data=0. mem_ready on that same edge wins (no error).
//   - req_valid changes from any requester are ignored (no new grant).
//  RESP: single cycle. resp_valid/resp_err high. rr_ptr <= (g+1) mod NUM_REQ.
//   Counter cleared. Next state IDLE; all resp outputs return to 0.
//  Throughput: a back-to-back grant is possible the cycle after RESP. mem_req is low for
//  at least 2 cycles between transactions (RESP + IDLE arbitration cycle).
//  Requester contract: hold req_valid and req_addr until req_ack. After req_ack, the
//  requester deasserts req_valid on the next edge, or a new request is taken.
//  Widths: g and rr_ptr $clog2(NUM_REQ); counter $clog2(TIMEOUT_CYCLES+1), saturating.
//  resp_data holds its last value outside RESP (consumers qualify with resp_valid).
// TESTING
//  1. req_valid=01, addr0=0x0000_1000. mem_ready 3 cycles after mem_req with data
//     0xDEADBEEF_...: req_ack=01 for 1 cycle, mem_addr=0x1000, resp_valid=01 next cycle.
//     resp_data matches, resp_err=0.
//  2. After reset, req_valid=11 held continuously with instant-ready memory: grant order
//     0,1,0,1. Each req_ack is one-hot. mem_req has a 2-cycle low gap between grants.
//  3. No mem_ready: exactly 64 BUSY cycles, then resp_valid[g]=1, resp_err=1,
//     resp_data=0. Then IDLE, and the next request is served normally.
//  4. rst pulsed during BUSY: mem_req=0 immediately. No resp_valid. The next req_valid=10
//     and 11 grant index 1 and 0 respectively (rr_ptr=0).
//  5. mem_ready pulse in IDLE, and again in RESP: no state change, no resp_valid.
//  6. mem_ready on the same edge the counter hits TIMEOUT_CYCLES: normal response with
//     resp_err=0.

Source files
------------

// File: rtl/mem_req_arbiter.sv
// Round-robin arbiter sharing one line-refill memory port between NUM_REQ requesters,
// with one outstanding transaction and a refill-timeout watchdog that returns an error response.
module mem_req_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int ADDR_W         = 32,
  parameter int LINE_W         = 128,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
  output logic [NUM_REQ-1:0]          req_ack,
  output logic [NUM_REQ-1:0]          resp_valid,
  output logic                        resp_err,
  output logic [LINE_W-1:0]           resp_data,
  output logic                        busy,
  output logic                        mem_req,
  output logic [ADDR_W-1:0]           mem_addr,
  input  logic [LINE_W-1:0]           mem_data_in,
  input  logic                        mem_ready
);

  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  logic [1:0]          state_q, state_d;
  logic [GW-1:0]       rr_ptr_q, rr_ptr_d;
  logic [GW-1:0]       grant_q, grant_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [NUM_REQ-1:0]  req_ack_q, req_ack_d;
  logic [NUM_REQ-1:0]  resp_valid_q, resp_valid_d;
  logic                resp_err_q, resp_err_d;
  logic [LINE_W-1:0]   resp_data_q, resp_data_d;
  logic                busy_q, busy_d;
  logic                mem_req_q, mem_req_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;

  logic                arb_found_s;
  logic [GW-1:0]       arb_idx_s;
  logic [ADDR_W-1:0]   arb_addr_s;
  logic [NUM_REQ-1:0]  arb_onehot_s;
  logic [NUM_REQ-1:0]  grant_onehot_s;
  logic                timeout_s;

  // Round-robin pick: first pass covers [rr_ptr, NUM_REQ-1], second pass wraps to [0, rr_ptr-1].
  always_comb begin
    arb_found_s = 1'b0;
    arb_idx_s   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!arb_found_s && req_valid[i] && (GW'(i) >= rr_ptr_q)) begin
        arb_found_s = 1'b1;
        arb_idx_s   = GW'(i);
      end else begin
        arb_found_s = arb_found_s;
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!arb_found_s && req_valid[i]) begin
        arb_found_s = 1'b1;
        arb_idx_s   = GW'(i);
      end else begin
        arb_found_s = arb_found_s;
      end
    end
  end

  // Address mux and one-hot decodes for the new and the current grant.
  always_comb begin
    arb_addr_s     = '0;
    arb_onehot_s   = '0;
    grant_onehot_s = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      arb_onehot_s[i]   = (GW'(i) == arb_idx_s);
      grant_onehot_s[i] = (GW'(i) == grant_q);
      if (GW'(i) == arb_idx_s) begin
        arb_addr_s = req_addr[i*ADDR_W +: ADDR_W];
      end else begin
        arb_addr_s = arb_addr_s;
      end
    end
  end

  // Watchdog fires on the edge that ends the TIMEOUT_CYCLES-th BUSY cycle.
  always_comb begin
    if (TIMEOUT_CYCLES != 0) begin
      timeout_s = (cnt_q == CW'(TIMEOUT_CYCLES - 1));
    end else begin
      timeout_s = 1'b0;
    end
  end

  // Next-state and registered-output computation.
  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    grant_d      = grant_q;
    cnt_d        = cnt_q;
    req_ack_d    = '0;
    resp_valid_d = '0;
    resp_err_d   = 1'b0;
    resp_data_d  = resp_data_q;
    mem_req_d    = mem_req_q;
    mem_addr_d   = mem_addr_q;
    case (state_q)
      ST_IDLE: begin
        if (arb_found_s) begin
          state_d    = ST_BUSY;
          grant_d    = arb_idx_s;
          req_ack_d  = arb_onehot_s;
          mem_req_d  = 1'b1;
          mem_addr_d = arb_addr_s;
          cnt_d      = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (cnt_q != {CW{1'b1}}) begin
          cnt_d = cnt_q + CW'(1);
        end else begin
          cnt_d = cnt_q;
        end
        // A late mem_ready on the timeout edge still counts as a good response.
        if (mem_ready) begin
          state_d      = ST_RESP;
          resp_valid_d = grant_onehot_s;
          resp_data_d  = mem_data_in;
          mem_req_d    = 1'b0;
          mem_addr_d   = '0;
        end else if (timeout_s) begin
          state_d      = ST_RESP;
          resp_valid_d = grant_onehot_s;
          resp_err_d   = 1'b1;
          resp_data_d  = '0;
          mem_req_d    = 1'b0;
          mem_addr_d   = '0;
        end else begin
          state_d = ST_BUSY;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        if (grant_q == GW'(NUM_REQ - 1)) begin
          rr_ptr_d = '0;
        end else begin
          rr_ptr_d = grant_q + GW'(1);
        end
      end
      default: begin
        state_d    = ST_IDLE;
        cnt_d      = '0;
        mem_req_d  = 1'b0;
        mem_addr_d = '0;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers; reset abandons any transaction in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      rr_ptr_q     <= '0;
      grant_q      <= '0;
      cnt_q        <= '0;
      req_ack_q    <= '0;
      resp_valid_q <= '0;
      resp_err_q   <= 1'b0;
      resp_data_q  <= '0;
      busy_q       <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= '0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      grant_q      <= grant_d;
      cnt_q        <= cnt_d;
      req_ack_q    <= req_ack_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_data_q  <= resp_data_d;
      busy_q       <= busy_d;
      mem_req_q    <= mem_req_d;
      mem_addr_q   <= mem_addr_d;
    end
  end

  assign req_ack    = req_ack_q;
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_data  = resp_data_q;
  assign busy       = busy_q;
  assign mem_req    = mem_req_q;
  assign mem_addr   = mem_addr_q;

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed bench for mem_req_arbiter: grant order, handshake timing, watchdog and reset behaviour.
module tb_mem_req_arbiter;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [1:0]    req_valid = 2'b00;
  logic [63:0]   req_addr = 64'h0;
  logic [1:0]    req_ack;
  logic [1:0]    resp_valid;
  logic          resp_err;
  logic [127:0]  resp_data;
  logic          busy;
  logic          mem_req;
  logic [31:0]   mem_addr;
  logic [127:0]  mem_data_in = 128'h0;
  logic          mem_ready = 1'b0;

  int checks = 0;
  int errors = 0;

  localparam logic [127:0] LINE_A = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
  localparam logic [127:0] LINE_B = 128'h11112222_33334444_55556666_77778888;
  localparam logic [127:0] LINE_C = 128'hA5A5A5A5_5A5A5A5A_0F0F0F0F_F0F0F0F0;

  mem_req_arbiter #(
    .NUM_REQ(2), .ADDR_W(32), .LINE_W(128), .TIMEOUT_CYCLES(64)
  ) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr),
    .req_ack(req_ack), .resp_valid(resp_valid), .resp_err(resp_err),
    .resp_data(resp_data), .busy(busy), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_data_in(mem_data_in), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    checks++;
    if ({req_ack, resp_valid, resp_err, busy, mem_req} !== 7'b0 || mem_addr !== 32'h0 || resp_data !== 128'h0) begin
      errors++;
      $display("FAIL reset_outputs: ack=%b rv=%b err=%b busy=%b mreq=%b addr=%h data=%h, need all zero",
               req_ack, resp_valid, resp_err, busy, mem_req, mem_addr, resp_data);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    req_addr  = {32'h0, 32'h0000_1000};
    req_valid = 2'b01;
    tick();
    checks++;
    if (req_ack !== 2'b01 || mem_req !== 1'b1 || mem_addr !== 32'h0000_1000 || busy !== 1'b1) begin
      errors++;
      $display("FAIL basic_grant: ack=%b mreq=%b addr=%h busy=%b, need 01 1 00001000 1", req_ack, mem_req, mem_addr, busy);
    end
    req_valid = 2'b00;
    tick();
    checks++;
    if (req_ack !== 2'b00 || mem_req !== 1'b1 || mem_addr !== 32'h0000_1000) begin
      errors++;
      $display("FAIL basic_ack_pulse: ack=%b mreq=%b addr=%h, need 00 1 00001000", req_ack, mem_req, mem_addr);
    end
    tick();
    mem_ready   = 1'b1;
    mem_data_in = LINE_A;
    tick();
    mem_ready = 1'b0;
    checks++;
    if (resp_valid !== 2'b01 || resp_err !== 1'b0 || resp_data !== LINE_A || mem_req !== 1'b0 || mem_addr !== 32'h0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL basic_resp: rv=%b err=%b data=%h mreq=%b addr=%h busy=%b, need 01 0 %h 0 0 1",
               resp_valid, resp_err, resp_data, mem_req, mem_addr, busy, LINE_A);
    end
    tick();
    checks++;
    if (resp_valid !== 2'b00 || busy !== 1'b0 || resp_data !== LINE_A) begin
      errors++;
      $display("FAIL basic_after_resp: rv=%b busy=%b data=%h, need 00 0 %h", resp_valid, busy, resp_data, LINE_A);
    end
  endtask

  task automatic test_round_robin();
    logic [1:0]  exp_oh;
    logic [31:0] exp_addr;
    do_reset();
    req_addr    = {32'hB000_0040, 32'hA000_0080};
    req_valid   = 2'b11;
    mem_ready   = 1'b1;
    mem_data_in = LINE_B;
    for (int k = 0; k < 4; k++) begin
      exp_oh   = (k % 2 == 0) ? 2'b01 : 2'b10;
      exp_addr = (k % 2 == 0) ? 32'hA000_0080 : 32'hB000_0040;
      tick();
      checks++;
      if (req_ack !== exp_oh || mem_req !== 1'b1 || mem_addr !== exp_addr) begin
        errors++;
        $display("FAIL rr_grant%0d: ack=%b mreq=%b addr=%h, need %b 1 %h", k, req_ack, mem_req, mem_addr, exp_oh, exp_addr);
      end
      tick();
      checks++;
      if (resp_valid !== exp_oh || req_ack !== 2'b00 || mem_req !== 1'b0 || resp_data !== LINE_B) begin
        errors++;
        $display("FAIL rr_resp%0d: rv=%b ack=%b mreq=%b data=%h, need %b 00 0 %h", k, resp_valid, req_ack, mem_req, resp_data, exp_oh, LINE_B);
      end
      tick();
      checks++;
      if (mem_req !== 1'b0 || req_ack !== 2'b00 || resp_valid !== 2'b00 || busy !== 1'b0) begin
        errors++;
        $display("FAIL rr_gap%0d: mreq=%b ack=%b rv=%b busy=%b, need 0 00 00 0", k, mem_req, req_ack, resp_valid, busy);
      end
    end
    req_valid = 2'b00;
    mem_ready = 1'b0;
    tick();
  endtask

  task automatic test_timeout();
    int busy_cycles;
    req_addr  = {32'hC000_0100, 32'h0};
    req_valid = 2'b10;
    tick();
    checks++;
    if (req_ack !== 2'b10) begin
      errors++;
      $display("FAIL to_grant: ack=%b, need 10", req_ack);
    end
    req_valid   = 2'b00;
    busy_cycles = 0;
    for (int n = 0; n < 200; n++) begin
      if (mem_req === 1'b1) busy_cycles++;
      if (resp_valid !== 2'b00) break;
      tick();
    end
    checks++;
    if (busy_cycles !== 64) begin
      errors++;
      $display("FAIL to_busy_cycles: counted %0d, need 64", busy_cycles);
    end
    checks++;
    if (resp_valid !== 2'b10 || resp_err !== 1'b1 || resp_data !== 128'h0 || mem_req !== 1'b0) begin
      errors++;
      $display("FAIL to_resp: rv=%b err=%b data=%h mreq=%b, need 10 1 0 0", resp_valid, resp_err, resp_data, mem_req);
    end
    tick();
    checks++;
    if (busy !== 1'b0 || resp_valid !== 2'b00 || resp_err !== 1'b0) begin
      errors++;
      $display("FAIL to_idle: busy=%b rv=%b err=%b, need 0 00 0", busy, resp_valid, resp_err);
    end
    req_addr  = {32'h0, 32'h0000_2000};
    req_valid = 2'b01;
    tick();
    req_valid   = 2'b00;
    mem_ready   = 1'b1;
    mem_data_in = LINE_C;
    checks++;
    if (req_ack !== 2'b01 || mem_addr !== 32'h0000_2000) begin
      errors++;
      $display("FAIL to_next_grant: ack=%b addr=%h, need 01 00002000", req_ack, mem_addr);
    end
    tick();
    mem_ready = 1'b0;
    checks++;
    if (resp_valid !== 2'b01 || resp_err !== 1'b0 || resp_data !== LINE_C) begin
      errors++;
      $display("FAIL to_next_resp: rv=%b err=%b data=%h, need 01 0 %h", resp_valid, resp_err, resp_data, LINE_C);
    end
    tick();
  endtask

  task automatic test_reset_mid_busy();
    req_addr  = {32'hD000_0000, 32'h0};
    req_valid = 2'b10;
    tick();
    req_valid = 2'b00;
    tick();
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (mem_req !== 1'b0 || busy !== 1'b0 || mem_addr !== 32'h0) begin
      errors++;
      $display("FAIL rst_async: mreq=%b busy=%b addr=%h, need 0 0 0", mem_req, busy, mem_addr);
    end
    tick();
    rst       = 1'b0;
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    checks++;
    if (resp_valid !== 2'b00 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_no_resp: rv=%b busy=%b, need 00 0", resp_valid, busy);
    end
    req_addr  = {32'hE000_0010, 32'hF000_0020};
    req_valid = 2'b11;
    tick();
    req_valid   = 2'b00;
    mem_ready   = 1'b1;
    mem_data_in = LINE_A;
    checks++;
    if (req_ack !== 2'b01 || mem_addr !== 32'hF000_0020) begin
      errors++;
      $display("FAIL rst_rrptr: ack=%b addr=%h, need 01 f0000020", req_ack, mem_addr);
    end
    tick();
    mem_ready = 1'b0;
    tick();
    req_valid = 2'b10;
    tick();
    req_valid = 2'b00;
    mem_ready = 1'b1;
    checks++;
    if (req_ack !== 2'b10 || mem_addr !== 32'hE000_0010) begin
      errors++;
      $display("FAIL rst_grant1: ack=%b addr=%h, need 10 e0000010", req_ack, mem_addr);
    end
    tick();
    mem_ready = 1'b0;
    tick();
  endtask

  task automatic test_stray_ready();
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    checks++;
    if (resp_valid !== 2'b00 || busy !== 1'b0 || mem_req !== 1'b0) begin
      errors++;
      $display("FAIL stray_idle: rv=%b busy=%b mreq=%b, need 00 0 0", resp_valid, busy, mem_req);
    end
    req_addr  = {32'h0, 32'h0000_3000};
    req_valid = 2'b01;
    tick();
    req_valid   = 2'b00;
    mem_ready   = 1'b1;
    mem_data_in = LINE_B;
    tick();
    checks++;
    if (resp_valid !== 2'b01 || resp_data !== LINE_B) begin
      errors++;
      $display("FAIL stray_setup: rv=%b data=%h, need 01 %h", resp_valid, resp_data, LINE_B);
    end
    tick();
    checks++;
    if (resp_valid !== 2'b00 || busy !== 1'b0 || mem_req !== 1'b0) begin
      errors++;
      $display("FAIL stray_resp: rv=%b busy=%b mreq=%b, need 00 0 0", resp_valid, busy, mem_req);
    end
    mem_ready = 1'b0;
    tick();
    checks++;
    if (resp_valid !== 2'b00 || busy !== 1'b0) begin
      errors++;
      $display("FAIL stray_after: rv=%b busy=%b, need 00 0", resp_valid, busy);
    end
  endtask

  task automatic test_timeout_race();
    req_addr  = {32'h0, 32'h0000_4000};
    req_valid = 2'b01;
    tick();
    req_valid = 2'b00;
    for (int n = 0; n < 63; n++) tick();
    checks++;
    if (resp_valid !== 2'b00 || mem_req !== 1'b1) begin
      errors++;
      $display("FAIL race_early: rv=%b mreq=%b in BUSY cycle 64, need 00 1", resp_valid, mem_req);
    end
    mem_ready   = 1'b1;
    mem_data_in = LINE_C;
    tick();
    mem_ready = 1'b0;
    checks++;
    if (resp_valid !== 2'b01 || resp_err !== 1'b0 || resp_data !== LINE_C) begin
      errors++;
      $display("FAIL race_resp: rv=%b err=%b data=%h, need 01 0 %h", resp_valid, resp_err, resp_data, LINE_C);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_round_robin();
    test_timeout();
    test_reset_mid_busy();
    test_stray_ready();
    test_timeout_race();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
